// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB first, carry held
// in a register between slices. Valid/ready on both sides, all outputs registered.
module seq_chunk_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [31:0]      sh;
  logic [WIDTH-1:0] a_sh, b_sh, mask, res_w;
  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   tot;
  logic             c_msb_in;

  // Current slice of each operand and its sum with the running carry
  always_comb begin
    sh       = 32'(idx_q) * 32'(CHUNK);
    a_sh     = a_q >> sh;
    b_sh     = b_q >> sh;
    a_sl     = a_sh[CHUNK-1:0];
    b_sl     = b_sh[CHUNK-1:0];
    tot      = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    // carry into the slice MSB recovered from its sum bit
    c_msb_in = tot[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];
    mask     = WIDTH'({CHUNK{1'b1}}) << sh;
    res_w    = WIDTH'(tot[CHUNK-1:0]) << sh;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: if (in_valid && in_ready_q) begin
        a_d        = in_a;
        b_d        = sub ? ~in_b : in_b;
        carry_d    = sub | cin;
        idx_d      = '0;
        in_ready_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        sum_d   = (sum_q & ~mask) | res_w;
        carry_d = tot[CHUNK];
        if (idx_q == IW'(NCHUNK - 1)) begin
          cout_d      = tot[CHUNK];
          ovf_d       = c_msb_in ^ tot[CHUNK];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Directed bench for seq_chunk_addsub: a 16/4 instance and a 32/8 instance share clock and reset.
module tb_seq_chunk_addsub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf;
  logic [15:0] n_a, n_b, n_sum;
  logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [31:0] w_a, w_b, w_sum;

  int checks = 0;
  int errors = 0;

  seq_chunk_addsub #(.WIDTH(16), .CHUNK(4)) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_a), .in_b(n_b), .cin(n_cin), .sub(n_sub),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .sum(n_sum), .cout(n_cout), .ovf(n_ovf));

  seq_chunk_addsub #(.WIDTH(32), .CHUNK(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_a), .in_b(w_b), .cin(w_cin), .sub(w_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .cout(w_cout), .ovf(w_ovf));

  // Launch one operation, wait (bounded) for the result, then drain it.
  task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic sb, output logic [31:0] s,
                        output logic co, output logic ov, output int lat);
    logic ov_v;
    @(negedge clk);
    if (wide) begin w_a = a; w_b = b; w_cin = ci; w_sub = sb; w_in_valid = 1'b1; end
    else begin n_a = a[15:0]; n_b = b[15:0]; n_cin = ci; n_sub = sb; n_in_valid = 1'b1; end
    @(posedge clk); #1;
    n_in_valid = 1'b0; w_in_valid = 1'b0;
    lat = 0;
    ov_v = wide ? w_out_valid : n_out_valid;
    while (!ov_v && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      ov_v = wide ? w_out_valid : n_out_valid;
    end
    s  = wide ? w_sum : {16'h0, n_sum};
    co = wide ? w_cout : n_cout;
    ov = wide ? w_ovf : n_ovf;
    @(negedge clk);
    n_out_ready = 1'b1; w_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0; w_out_ready = 1'b0;
    checks++;
    if ((wide ? w_out_valid : n_out_valid) !== 1'b0 || (wide ? w_in_ready : n_in_ready) !== 1'b1) begin
      errors++;
      $display("FAIL drain w=%0d out_valid=%b in_ready=%b want 0/1", wide,
               wide ? w_out_valid : n_out_valid, wide ? w_in_ready : n_in_ready);
    end
  endtask

  task automatic check_op(input string name, input bit wide, input logic [31:0] a,
                          input logic [31:0] b, input logic ci, input logic sb,
                          input logic [31:0] es, input logic eco, input logic eov);
    logic [31:0] s; logic co, ov; int lat;
    run_op(wide, a, b, ci, sb, s, co, ov, lat);
    checks++;
    if (s !== es || co !== eco || ov !== eov) begin
      errors++;
      $display("FAIL %s sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", name, s, co, ov, es, eco, eov);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL %s_latency got %0d want 4", name, lat);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0 || n_sum !== 16'h0 || n_cout !== 1'b0 || n_ovf !== 1'b0 ||
        w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_sum !== 32'h0 || w_cout !== 1'b0 || w_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values n: rdy=%b vld=%b sum=%h w: rdy=%b vld=%b sum=%h want 1/0/0",
               n_in_ready, n_out_valid, n_sum, w_in_ready, w_out_valid, w_sum);
    end
    rst = 1'b1;
    // start an op and abort it mid-RUN
    @(negedge clk);
    n_a = 16'hFFFF; n_b = 16'h1111; n_cin = 1'b0; n_sub = 1'b0; n_in_valid = 1'b1;
    @(posedge clk); #1; n_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (n_in_ready !== 1'b0 || n_sum === 16'h0) begin
      errors++;
      $display("FAIL midrun in_ready=%b sum=%h want 0 and nonzero partial", n_in_ready, n_sum);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1 || n_sum !== 16'h0) begin
      errors++;
      $display("FAIL reset_midrun out_valid=%b in_ready=%b sum=%h want 0/1/0000", n_out_valid, n_in_ready, n_sum);
    end
    @(negedge clk); rst = 1'b1;
    check_op("after_reset", 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 32'h1, 1'b0, 1'b0);
  endtask

  task automatic test_arith16();
    check_op("best16",  1'b0, 32'h0000, 32'h0001, 1'b0, 1'b0, 32'h0001, 1'b0, 1'b0);
    check_op("chain16", 1'b0, 32'hAAAB, 32'h5555, 1'b1, 1'b0, 32'h0001, 1'b1, 1'b0);
    check_op("sub16",   1'b0, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFE, 1'b0, 1'b0);
    check_op("ovf16",   1'b0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
  endtask

  task automatic test_arith32();
    check_op("best32",  1'b1, 32'h0000, 32'h0001, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    check_op("chain32", 1'b1, 32'hAAAB, 32'h5555, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0);
    check_op("sub32",   1'b1, 32'h0005, 32'h0007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    check_op("ovf32",   1'b1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h00008000, 1'b0, 1'b0);
    check_op("ovfmax32", 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    n_a = 16'h0001; n_b = 16'h0002; n_cin = 1'b0; n_sub = 1'b0; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_a = 16'h0010; n_b = 16'h0020;  // new operands offered but must wait
    lat = 0;
    while (!n_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (n_out_valid !== 1'b1 || n_sum !== 16'h0003 || n_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d out_valid=%b sum=%h in_ready=%b want 1/0003/0", i, n_out_valid, n_sum, n_in_ready);
      end
    end
    @(negedge clk); n_out_ready = 1'b1;
    @(posedge clk); #1; n_out_ready = 1'b0;
    checks++;
    if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_transfer out_valid=%b in_ready=%b want 0/1", n_out_valid, n_in_ready);
    end
    @(posedge clk); #1; n_in_valid = 1'b0;
    checks++;
    if (n_in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept in_ready=%b want 0", n_in_ready); end
    lat = 0;
    while (!n_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (n_sum !== 16'h0030 || lat != 4) begin
      errors++;
      $display("FAIL bp_second sum=%h lat=%0d want 0030/4", n_sum, lat);
    end
    @(negedge clk); n_out_ready = 1'b1;
    @(posedge clk); #1; n_out_ready = 1'b0;
  endtask

  initial begin
    n_in_valid = 0; n_out_ready = 0; n_a = 0; n_b = 0; n_cin = 0; n_sub = 0;
    w_in_valid = 0; w_out_ready = 0; w_a = 0; w_b = 0; w_cin = 0; w_sub = 0;
    test_reset();
    test_arith16();
    test_arith32();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
